cont_monitor: RTL and testbench

//  Observing end of the cont2-style counter interface. Runs a cycle-accurate

---
 rtl/cont_monitor.sv | 115 +++++++++++
 tb/tb_cont_monitor.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/cont_monitor.sv
// Reference-model checker for a cont2-style counter: predicts Q/RCO from enb/modo/D
// and flags, counts and optionally halts on any disagreement with the real counter.
//
// state  | meaning
// UNSYNC | counter Q unknown; wait for a load to align the model
// CHECK  | model aligned; compare Q/RCO every cycle
// HALT   | stopped after a mismatch (STOP_ON_ERR=1); a load re-syncs
module cont_monitor #(
    parameter int WIDTH       = 4,
    parameter int CNT_W       = 8,
    parameter int STEP_DN3    = 3,
    parameter int STOP_ON_ERR = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enb,
    input  logic [1:0]       modo,
    input  logic [WIDTH-1:0] D,
    input  logic [WIDTH-1:0] Q,
    input  logic             RCO,
    output logic             synced,
    output logic             err,
    output logic             err_q,
    output logic             err_rco,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] chk_cnt,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        S_UNSYNC = 2'b00,
        S_CHECK  = 2'b01,
        S_HALT   = 2'b10
    } state_t;

    localparam logic [WIDTH-1:0] STEP = WIDTH'(STEP_DN3);
    localparam logic             STOP = (STOP_ON_ERR != 0);

    state_t           cur_state, nxt_state;
    logic [WIDTH-1:0] q_exp, q_nxt;
    logic             rco_exp, rco_nxt;
    logic             load, cmp, mq, mr, miss;

    assign load = enb && (modo == 2'b11);
    assign cmp  = (cur_state == S_CHECK);
    // Case-inequality so an undriven or X counter output is never taken as a match.
    assign mq   = cmp && (Q !== q_exp);
    assign mr   = cmp && (RCO !== rco_exp);
    assign miss = mq || mr;

    always_comb begin
        q_nxt   = q_exp;
        rco_nxt = rco_exp;
        if (enb) begin
            case (modo)
                2'b00: begin
                    q_nxt   = q_exp + WIDTH'(1);
                    rco_nxt = &q_exp;
                end
                2'b01: begin
                    q_nxt   = q_exp - WIDTH'(1);
                    rco_nxt = (q_exp == '0);
                end
                2'b10: begin
                    q_nxt   = q_exp - STEP;
                    rco_nxt = (q_exp < STEP);
                end
                default: begin
                    q_nxt   = D;
                    rco_nxt = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            S_UNSYNC: if (load) nxt_state = S_CHECK;
            S_CHECK:  if (STOP && miss) nxt_state = S_HALT;
            S_HALT:   if (load) nxt_state = S_CHECK;
            default:  nxt_state = S_UNSYNC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state <= S_UNSYNC;
            q_exp     <= '0;
            rco_exp   <= 1'b0;
            err       <= 1'b0;
            err_q     <= 1'b0;
            err_rco   <= 1'b0;
            err_cnt   <= '0;
            chk_cnt   <= '0;
        end else begin
            cur_state <= nxt_state;
            q_exp     <= q_nxt;
            rco_exp   <= rco_nxt;
            err       <= miss;
            if (cmp) begin
                err_q   <= err_q | mq;
                err_rco <= err_rco | mr;
                if (miss && (err_cnt != '1))
                    err_cnt <= err_cnt + CNT_W'(1);
                if (chk_cnt != '1)
                    chk_cnt <= chk_cnt + CNT_W'(1);
            end
        end
    end

    assign synced = (cur_state == S_CHECK) || (cur_state == S_HALT);
    assign state  = cur_state;

endmodule

// File: tb/tb_cont_monitor.sv
// Directed bench for cont_monitor: the bench plays the counter by driving Q/RCO,
// with one monitor free-running (STOP_ON_ERR=0) and one halting (STOP_ON_ERR=1).
module tb_cont_monitor;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enb = 1'b0;
    logic [1:0] modo = 2'b00;
    logic [3:0] D = 4'h0;
    logic [3:0] Q = 4'h0;
    logic       RCO = 1'b0;

    logic       synced0, err0, errq0, errr0, synced1, err1, errq1, errr1;
    logic [7:0] ecnt0, ccnt0, ecnt1, ccnt1;
    logic [1:0] st0, st1;

    int nvec = 0;
    int nmis = 0;

    always #5 clk = ~clk;

    cont_monitor #(.WIDTH(4), .CNT_W(8), .STEP_DN3(3), .STOP_ON_ERR(0)) dut0 (
        .clk(clk), .reset(reset), .enb(enb), .modo(modo), .D(D), .Q(Q), .RCO(RCO),
        .synced(synced0), .err(err0), .err_q(errq0), .err_rco(errr0),
        .err_cnt(ecnt0), .chk_cnt(ccnt0), .state(st0)
    );

    cont_monitor #(.WIDTH(4), .CNT_W(8), .STEP_DN3(3), .STOP_ON_ERR(1)) dut1 (
        .clk(clk), .reset(reset), .enb(enb), .modo(modo), .D(D), .Q(Q), .RCO(RCO),
        .synced(synced1), .err(err1), .err_q(errq1), .err_rco(errr1),
        .err_cnt(ecnt1), .chk_cnt(ccnt1), .state(st1)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        nvec++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: apply controls, take the edge, then present the counter's new Q/RCO.
    task automatic cyc(input logic e, input logic [1:0] m, input logic [3:0] d,
                       input logic [3:0] qn, input logic rn);
        enb  = e;
        modo = m;
        D    = d;
        @(posedge clk);
        #1;
        Q   = qn;
        RCO = rn;
    endtask

    initial begin
        reset = 1'b1;
        cyc(1'b0, 2'b00, 4'h0, 4'h0, 1'b0);
        cyc(1'b1, 2'b11, 4'h7, 4'h0, 1'b0);
        chk2("rst_state0", st0, 2'd0);
        chk1("rst_synced0", synced0, 1'b0);
        chk1("rst_err0", err0, 1'b0);
        chk8("rst_chk0", ccnt0, 8'd0);
        chk2("rst_state1", st1, 2'd0);
        reset = 1'b0;

        // count up through the wrap
        cyc(1'b1, 2'b11, 4'hE, 4'hE, 1'b0);
        chk2("t1_state", st0, 2'd1);
        chk1("t1_synced", synced0, 1'b1);
        chk8("t1_chk_load", ccnt0, 8'd0);
        cyc(1'b1, 2'b00, 4'h0, 4'hF, 1'b0);
        chk1("t1_err_a", err0, 1'b0);
        cyc(1'b1, 2'b00, 4'h0, 4'h0, 1'b1);
        chk1("t1_err_b", err0, 1'b0);
        cyc(1'b1, 2'b00, 4'h0, 4'h1, 1'b0);
        chk1("t1_err_c", err0, 1'b0);
        chk8("t1_chk", ccnt0, 8'd3);

        // count down through the wrap
        cyc(1'b1, 2'b11, 4'h1, 4'h1, 1'b0);
        cyc(1'b1, 2'b01, 4'h0, 4'h0, 1'b0);
        cyc(1'b1, 2'b01, 4'h0, 4'hF, 1'b1);
        cyc(1'b1, 2'b01, 4'h0, 4'hE, 1'b0);
        chk1("t2_err", err0, 1'b0);
        chk8("t2_chk", ccnt0, 8'd7);

        // step by 3 through the wrap
        cyc(1'b1, 2'b11, 4'h4, 4'h4, 1'b0);
        cyc(1'b1, 2'b10, 4'h0, 4'h1, 1'b0);
        cyc(1'b1, 2'b10, 4'h0, 4'hE, 1'b1);
        cyc(1'b1, 2'b10, 4'h0, 4'hB, 1'b0);
        chk1("t3_err", err0, 1'b0);
        chk8("t3_errcnt", ecnt0, 8'd0);
        chk1("t3_errq", errq0, 1'b0);
        chk8("t3_chk", ccnt0, 8'd11);

        // Q=5 presented while the model holds 6
        cyc(1'b1, 2'b11, 4'h6, 4'h5, 1'b0);
        chk1("t4_err_pre", err0, 1'b0);
        cyc(1'b0, 2'b00, 4'h0, 4'h6, 1'b0);
        chk1("t4_err", err0, 1'b1);
        chk1("t4_errq", errq0, 1'b1);
        chk1("t4_errrco", errr0, 1'b0);
        chk8("t4_errcnt", ecnt0, 8'd1);
        chk2("t4_halt1", st1, 2'd2);
        cyc(1'b0, 2'b00, 4'h0, 4'h6, 1'b0);
        chk1("t4_err_pulse", err0, 1'b0);
        chk8("t4_chk", ccnt0, 8'd14);

        // enable low: model must hold
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 2'b01, 4'h0, 4'h6, 1'b0);
            chk1("t6_hold_err", err0, 1'b0);
        end
        cyc(1'b1, 2'b00, 4'h0, 4'h7, 1'b0);
        cyc(1'b1, 2'b00, 4'h0, 4'h8, 1'b0);
        chk1("t6_resume_err", err0, 1'b0);
        chk8("t6_errcnt", ecnt0, 8'd1);
        chk8("t6_chk", ccnt0, 8'd21);
        chk8("t6_halt_chk1", ccnt1, 8'd13);
        chk1("t6_halt_err1", err1, 1'b0);

        // reset mid-run
        reset = 1'b1;
        cyc(1'b1, 2'b00, 4'h0, 4'h9, 1'b0);
        reset = 1'b0;
        chk2("t6_rst_state", st0, 2'd0);
        chk8("t6_rst_errcnt", ecnt0, 8'd0);
        chk8("t6_rst_chk", ccnt0, 8'd0);
        chk1("t6_rst_errq", errq0, 1'b0);
        chk2("t6_rst_state1", st1, 2'd0);

        // RCO wrong: halting monitor freezes, free-running one keeps counting
        cyc(1'b1, 2'b11, 4'h3, 4'h3, 1'b0);
        cyc(1'b1, 2'b00, 4'h0, 4'h4, 1'b1);
        chk1("t5_err_pre", err1, 1'b0);
        cyc(1'b0, 2'b00, 4'h0, 4'h4, 1'b1);
        chk2("t5_halt", st1, 2'd2);
        chk1("t5_err1", err1, 1'b1);
        chk1("t5_errrco1", errr1, 1'b1);
        chk1("t5_errq1", errq1, 1'b0);
        chk8("t5_errcnt1", ecnt1, 8'd1);
        chk1("t5_synced_halt", synced1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 2'b00, 4'h0, 4'h4, 1'b1);
            chk1("t5_halt_err1", err1, 1'b0);
            chk1("t5_run_err0", err0, 1'b1);
        end
        chk8("t5_frozen_errcnt1", ecnt1, 8'd1);
        chk8("t5_frozen_chk1", ccnt1, 8'd2);
        chk8("t5_errcnt0", ecnt0, 8'd11);
        chk8("t5_chk0", ccnt0, 8'd12);
        cyc(1'b1, 2'b11, 4'h9, 4'h9, 1'b0);
        chk2("t5_resync", st1, 2'd1);
        chk8("t5_errcnt0_load", ecnt0, 8'd12);
        cyc(1'b0, 2'b00, 4'h0, 4'h9, 1'b0);
        chk1("t5_after_err1", err1, 1'b0);
        chk8("t5_after_chk1", ccnt1, 8'd3);
        chk8("t5_after_errcnt1", ecnt1, 8'd1);
        chk8("t5_after_chk0", ccnt0, 8'd14);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
